bus_gen_arbiter: RTL and testbench



---
 rtl/bus_gen_arbiter_pkg.sv | 31 +++
 rtl/bus_lane_arbiter.sv | 88 ++++++++
 rtl/bus_gen_arbiter.sv | 42 ++++
 tb/tb_bus_gen_arbiter.sv | 162 ++++++++++++++++
 4 files changed

// File: rtl/bus_gen_arbiter_pkg.sv
// Shared types and helpers for the bus generator/arbiter lanes.
// Macro LOOPBACK_EN: self-addressed packets go back to the source, and broadcast includes the source.
package bus_gen_arbiter_pkg;

  localparam int ID_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    POP  = 2'd1,
    PUSH = 2'd2
  } lane_state_e;

  // The destination ID occupies the top ID_W bits of a packet.
  function automatic int id_lsb(input int pkt_w);
    return pkt_w - ID_W;
  endfunction

  // One bit of the push mask: does device k receive packet with this ID sent by src?
  function automatic logic push_hit(input logic [ID_W-1:0] id, input int src, input int k,
                                    input int drvrs, input logic [ID_W-1:0] bcast);
`ifdef LOOPBACK_EN
    if (id == bcast) return 1'b1;
    return (int'(id) < drvrs) && (int'(id) == k);
`else
    if (k == src) return 1'b0;
    if (id == bcast) return 1'b1;
    return (int'(id) < drvrs) && (int'(id) == k);
`endif
  endfunction

endpackage

// File: rtl/bus_lane_arbiter.sv
// One bus lane: round-robin source pick, pop, capture, then push decode (IDLE -> POP -> PUSH).
// Macro LOOPBACK_EN alters the push decode (see package).
module bus_lane_arbiter
  import bus_gen_arbiter_pkg::*;
#(
  parameter int              drvrs     = 6,
  parameter int              pckg_sz   = 16,
  parameter logic [ID_W-1:0] broadcast = 8'hFF
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [drvrs-1:0]                pndng,
  output logic [drvrs-1:0]                pop,
  input  logic [drvrs-1:0][pckg_sz-1:0]   D_pop,
  output logic [drvrs-1:0]                push,
  output logic [pckg_sz-1:0]              D_push,
  output lane_state_e                     state_dbg
);

  localparam int SRC_W  = (drvrs > 1) ? $clog2(drvrs) : 1;
  localparam int ID_LSB = id_lsb(pckg_sz);

  lane_state_e        state_q, state_d;
  logic [SRC_W-1:0]   src_q, src_d;
  logic [SRC_W-1:0]   last_q, last_d;
  logic [SRC_W-1:0]   rr_sel, rr_idx;
  logic [pckg_sz-1:0] pkt_q, pkt_d;
  logic [ID_W-1:0]    pkt_id;

  assign pkt_id    = pkt_q[ID_LSB +: ID_W];
  assign D_push    = pkt_q;
  assign state_dbg = state_q;

  // Walk from farthest to nearest so the first pending device after last_grant wins.
  always_comb begin
    rr_sel = last_q;
    rr_idx = '0;
    for (int i = drvrs; i >= 1; i--) begin
      rr_idx = SRC_W'((int'(last_q) + i) % drvrs);
      if (pndng[rr_idx]) rr_sel = rr_idx;
    end
  end

  always_comb begin
    state_d = state_q;
    src_d   = src_q;
    last_d  = last_q;
    pkt_d   = pkt_q;
    pop     = '0;
    push    = '0;
    unique case (state_q)
      IDLE: begin
        if (|pndng) begin
          src_d   = rr_sel;
          state_d = POP;
        end
      end
      POP: begin
        pop[src_q] = 1'b1;
        pkt_d      = D_pop[src_q];
        last_d     = src_q;
        state_d    = PUSH;
      end
      PUSH: begin
        for (int k = 0; k < drvrs; k++) begin
          push[k] = push_hit(pkt_id, int'(src_q), k, drvrs, broadcast);
        end
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      src_q   <= '0;
      last_q  <= SRC_W'(drvrs - 1);
      pkt_q   <= '0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      last_q  <= last_d;
      pkt_q   <= pkt_d;
    end
  end

endmodule

// File: rtl/bus_gen_arbiter.sv
// Shared-bus generator/arbiter: `bits` independent lanes of `drvrs` devices each.
// Macro LOOPBACK_EN enables loopback of self-addressed and broadcast packets.
module bus_gen_arbiter
  import bus_gen_arbiter_pkg::*;
#(
  parameter int              bits      = 1,
  parameter int              drvrs     = 6,
  parameter int              pckg_sz   = 16,
  parameter logic [ID_W-1:0] broadcast = 8'hFF
) (
  input  logic                                     clk,
  input  logic                                     reset,
  input  logic [bits-1:0][drvrs-1:0]               pndng,
  output logic [bits-1:0][drvrs-1:0]               pop,
  input  logic [bits-1:0][drvrs-1:0][pckg_sz-1:0]  D_pop,
  output logic [bits-1:0][drvrs-1:0]               push,
  output logic [bits-1:0][pckg_sz-1:0]             D_push,
  output logic [bits-1:0][1:0]                     state_dbg
);

  for (genvar l = 0; l < bits; l++) begin : g_lane
    lane_state_e lane_state;

    bus_lane_arbiter #(
      .drvrs     (drvrs),
      .pckg_sz   (pckg_sz),
      .broadcast (broadcast)
    ) u_lane (
      .clk       (clk),
      .reset     (reset),
      .pndng     (pndng[l]),
      .pop       (pop[l]),
      .D_pop     (D_pop[l]),
      .push      (push[l]),
      .D_push    (D_push[l]),
      .state_dbg (lane_state)
    );

    assign state_dbg[l] = lane_state;
  end

endmodule

// File: tb/tb_bus_gen_arbiter.sv
// Directed bench for bus_gen_arbiter (one lane, six devices, 16-bit packets).
module tb_bus_gen_arbiter;
  import bus_gen_arbiter_pkg::*;

  logic                    clk;
  logic                    reset;
  logic [0:0][5:0]         pndng;
  logic [0:0][5:0]         pop;
  logic [0:0][5:0][15:0]   d_pop;
  logic [0:0][5:0]         push;
  logic [0:0][15:0]        d_push;
  logic [0:0][1:0]         state_dbg;

  int checks;
  int passes;

  bus_gen_arbiter #(.bits(1), .drvrs(6), .pckg_sz(16), .broadcast(8'hFF)) dut (
    .clk       (clk),
    .reset     (reset),
    .pndng     (pndng),
    .pop       (pop),
    .D_pop     (d_pop),
    .push      (push),
    .D_push    (d_push),
    .state_dbg (state_dbg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_pop"},   32'(pop[0]),  32'h0);
    check({tag, "_push"},  32'(push[0]), 32'h0);
    check({tag, "_state"}, 32'(state_dbg[0]), 32'(IDLE));
  endtask

  task automatic do_reset();
    reset = 1'b1;
    pndng = '0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  initial begin
    checks = 0;
    passes = 0;
    d_pop  = '0;
    do_reset();

    // Reset state
    check_idle_outputs("reset");
    check("reset_dpush", 32'(d_push[0]), 32'h0);

    // Unicast: device 0 -> device 3
    pndng[0][0] = 1'b1;
    d_pop[0][0] = 16'h0355;
    tick();
    check("uni_pop", 32'(pop[0]), 32'h01);
    check("uni_pop_nopush", 32'(push[0]), 32'h0);
    pndng = '0;
    tick();
    check("uni_push", 32'(push[0]), 32'h08);
    check("uni_push_nopop", 32'(pop[0]), 32'h0);
    check("uni_dpush", 32'(d_push[0]), 32'h0355);
    tick();
    check_idle_outputs("uni_after");
    check("uni_dpush_hold", 32'(d_push[0]), 32'h0355);

    // Broadcast from device 2
    pndng[0][2] = 1'b1;
    d_pop[0][2] = 16'hFF12;
    tick();
    check("bc_pop", 32'(pop[0]), 32'h04);
    pndng = '0;
    tick();
`ifdef LOOPBACK_EN
    check("bc_push", 32'(push[0]), 32'h3F);
`else
    check("bc_push", 32'(push[0]), 32'h3B);
`endif
    check("bc_dpush", 32'(d_push[0]), 32'hFF12);
    tick();
    check_idle_outputs("bc_after");

    // Invalid ID 10 from device 1 (search starts at 3, wraps to 1)
    pndng[0][1] = 1'b1;
    d_pop[0][1] = 16'h0A01;
    tick();
    check("inv_pop", 32'(pop[0]), 32'h02);
    pndng = '0;
    tick();
    check("inv_push", 32'(push[0]), 32'h0);
    check("inv_state", 32'(state_dbg[0]), 32'(PUSH));
    tick();
    check_idle_outputs("inv_after");

    // Self-address from device 4
    pndng[0][4] = 1'b1;
    d_pop[0][4] = 16'h0477;
    tick();
    check("self_pop", 32'(pop[0]), 32'h10);
    pndng = '0;
    tick();
`ifdef LOOPBACK_EN
    check("self_push", 32'(push[0]), 32'h10);
`else
    check("self_push", 32'(push[0]), 32'h0);
`endif
    check("self_dpush", 32'(d_push[0]), 32'h0477);
    tick();
    check_idle_outputs("self_after");

    // Round-robin with all devices pending: device k sends to (k+1)%6
    do_reset();
    for (int k = 0; k < 6; k++) d_pop[0][k] = {8'((k + 1) % 6), 8'(k)};
    pndng[0] = 6'h3F;
    for (int n = 0; n < 7; n++) begin
      tick();
      check($sformatf("rr%0d_pop", n), 32'(pop[0]), 32'(1) << (n % 6));
      check($sformatf("rr%0d_nopush", n), 32'(push[0]), 32'h0);
      tick();
      check($sformatf("rr%0d_push", n), 32'(push[0]), 32'(1) << ((n % 6 + 1) % 6));
      check($sformatf("rr%0d_dpush", n), 32'(d_push[0]), 32'({8'((n % 6 + 1) % 6), 8'(n % 6)}));
      tick();
      check($sformatf("rr%0d_gap", n), 32'(pop[0]), 32'h0);
    end

    // Reset during PUSH aborts, then device 0 has priority again
    do_reset();
    pndng[0][3] = 1'b1;
    d_pop[0][3] = 16'h0155;
    tick();
    check("rst_pop", 32'(pop[0]), 32'h08);
    pndng = '0;
    tick();
    check("rst_push_before", 32'(push[0]), 32'h02);
    reset = 1'b1;
    pndng[0] = 6'h3F;
    tick();
    check_idle_outputs("rst_abort");
    check("rst_dpush", 32'(d_push[0]), 32'h0);
    reset = 1'b0;
    tick();
    check("rst_first_grant", 32'(pop[0]), 32'h01);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
